// File: rtl/ysyx_25050141_lsu_if.sv
// Memory-side bus of the load/store unit: a request channel carrying a
// word-aligned address with byte strobes, and a response channel returning
// the read word. The LSU drives the master view, the memory the slave view.
interface ysyx_25050141_lsu_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req_valid,
      input  mem_req_ready,
      output mem_addr,
      output mem_wen,
      output mem_wstrb,
      output mem_wdata,
      input  mem_resp_valid,
      output mem_resp_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_req_valid,
      output mem_req_ready,
      input  mem_addr,
      input  mem_wen,
      input  mem_wstrb,
      input  mem_wdata,
      output mem_resp_valid,
      input  mem_resp_ready,
      output mem_rdata
   );
endinterface

// File: rtl/ysyx_25050141_lsu.sv
// Load/store unit: takes one memory op from EX, checks alignment, issues a
// single request on the memory bus, waits (bounded by TIMEOUT cycles) for the
// response, then presents one completion beat to the register-file write port.
// Only one op is ever in flight.
module ysyx_25050141_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic        ex_wen,
   input  logic [1:0]  ex_size,
   input  logic        ex_unsigned,
   input  logic [4:0]  ex_rd,
   ysyx_25050141_lsu_if.master mem,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exc
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   localparam logic [8:0] TIMEOUT_C = {1'b0, 8'(TIMEOUT)};

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wen_q, wen_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [4:0]  rd_q, rd_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_exc_q, wb_exc_d;

   logic        ex_misaligned;
   logic [3:0]  store_strb;
   logic [31:0] store_lanes;
   logic [31:0] load_shifted;
   logic [31:0] load_data;
   logic [7:0]  cnt_inc;
   logic        timeout_hit;
   logic        in_req;
   logic        in_wb;

   // Alignment check on the incoming op; size 11 is never legal.
   always_comb begin
      ex_misaligned = 1'b0;
      case (ex_size)
         2'b00:   ex_misaligned = 1'b0;
         2'b01:   ex_misaligned = ex_addr[0];
         2'b10:   ex_misaligned = (ex_addr[1:0] != 2'b00);
         default: ex_misaligned = 1'b1;
      endcase
   end

   // Byte strobes and lane replication for the captured store.
   always_comb begin
      store_strb  = 4'b0000;
      store_lanes = 32'd0;
      case (size_q)
         2'b00: begin
            store_strb  = 4'b0001 << addr_q[1:0];
            store_lanes = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            store_strb  = 4'b0011 << addr_q[1:0];
            store_lanes = {2{wdata_q[15:0]}};
         end
         default: begin
            store_strb  = 4'b1111;
            store_lanes = wdata_q;
         end
      endcase
   end

   // Pick the addressed bytes out of the read word and extend them to 32 bits.
   always_comb begin
      load_shifted = mem.mem_rdata >> {addr_q[1:0], 3'b000};
      load_data    = load_shifted;
      case (size_q)
         2'b00:   load_data = {{24{~unsigned_q & load_shifted[7]}}, load_shifted[7:0]};
         2'b01:   load_data = {{16{~unsigned_q & load_shifted[15]}}, load_shifted[15:0]};
         default: load_data = load_shifted;
      endcase
   end

   // Response-wait counter: saturating increment, and the abort condition
   // fires on the cycle the counter would reach TIMEOUT.
   always_comb begin
      cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      timeout_hit = ({1'b0, cnt_q} + 9'd1) >= TIMEOUT_C;
   end

   // Next-state logic: capture the op on accept, walk IDLE/REQ/RESP/WB and
   // latch the completion data and exception flag on the way into WB.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wen_d      = wen_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      wb_data_d  = wb_data_q;
      wb_exc_d   = wb_exc_q;
      case (state_q)
         S_IDLE: begin
            if (ex_valid) begin
               addr_d     = ex_addr;
               wdata_d    = ex_wdata;
               wen_d      = ex_wen;
               size_d     = ex_size;
               unsigned_d = ex_unsigned;
               rd_d       = ex_rd;
               wb_data_d  = 32'd0;
               wb_exc_d   = ex_misaligned;
               state_d    = ex_misaligned ? S_WB : S_REQ;
            end
         end
         S_REQ: begin
            if (mem.mem_req_ready) begin
               state_d = S_RESP;
               cnt_d   = 8'd0;
            end
         end
         S_RESP: begin
            if (mem.mem_resp_valid) begin
               state_d   = S_WB;
               wb_exc_d  = 1'b0;
               wb_data_d = wen_q ? 32'd0 : load_data;
            end else begin
               cnt_d = cnt_inc;
               if (timeout_hit) begin
                  state_d   = S_WB;
                  wb_exc_d  = 1'b1;
                  wb_data_d = 32'd0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight op and returns to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         wen_q      <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         rd_q       <= 5'd0;
         cnt_q      <= 8'd0;
         wb_data_q  <= 32'd0;
         wb_exc_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wen_q      <= wen_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         wb_data_q  <= wb_data_d;
         wb_exc_q   <= wb_exc_d;
      end
   end

   // Outputs are decoded from the state so everything idles at zero, and the
   // request fields stay stable for as long as the memory holds off ready.
   always_comb begin
      in_req              = (state_q == S_REQ);
      in_wb               = (state_q == S_WB);
      ex_ready            = (state_q == S_IDLE);
      mem.mem_req_valid   = in_req;
      mem.mem_addr        = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
      mem.mem_wen         = in_req & wen_q;
      mem.mem_wstrb       = (in_req & wen_q) ? store_strb : 4'b0000;
      mem.mem_wdata       = (in_req & wen_q) ? store_lanes : 32'd0;
      mem.mem_resp_ready  = (state_q == S_RESP);
      wb_valid            = in_wb;
      wb_exc              = in_wb & wb_exc_q;
      wb_data             = in_wb ? wb_data_q : 32'd0;
      wb_rd               = in_wb ? rd_q : 5'd0;
      wb_we               = in_wb & ~wb_exc_q & ~wen_q & (rd_q != 5'd0);
   end

endmodule

// File: tb/tb_ysyx_25050141_lsu.sv
// Directed bench for the load/store unit: each op is driven from EX, the
// memory side is played by hand, and every observed value is compared
// against a hand-computed constant.
module tb_ysyx_25050141_lsu;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_addr;
   logic [31:0] ex_wdata;
   logic        ex_wen;
   logic [1:0]  ex_size;
   logic        ex_unsigned;
   logic [4:0]  ex_rd;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_exc;

   int checks;
   int failures;

   ysyx_25050141_lsu_if mem ();

   ysyx_25050141_lsu #(.TIMEOUT(255)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .ex_addr     (ex_addr),
      .ex_wdata    (ex_wdata),
      .ex_wen      (ex_wen),
      .ex_size     (ex_size),
      .ex_unsigned (ex_unsigned),
      .ex_rd       (ex_rd),
      .mem         (mem.master),
      .wb_valid    (wb_valid),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_exc      (wb_exc)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                                input logic w, input logic [1:0] s, input logic u, input logic [4:0] r);
      ex_valid    = v;
      ex_addr     = a;
      ex_wdata    = d;
      ex_wen      = w;
      ex_size     = s;
      ex_unsigned = u;
      ex_rd       = r;
   endtask

   task automatic runOp(input string name,
                        input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [1:0] s, input logic u, input logic [4:0] r,
                        input logic [31:0] rdata, input int reqStall, input int respDelay,
                        input logic expMis, input logic [31:0] expAddr, input logic [3:0] expStrb,
                        input logic [31:0] expWdata, input logic [31:0] expData,
                        input logic expWe, input logic expExc, input int expLat);
      int cyc;
      @(negedge clk);
      applyStimulus(1'b1, a, d, w, s, u, r);
      checkOutput({name, ".ex_ready"}, ex_ready, 1);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 5'd0);
      cyc = 1;
      if (expMis) begin
         checkOutput({name, ".req_valid"}, mem.mem_req_valid, 0);
      end else begin
         checkOutput({name, ".req_valid"}, mem.mem_req_valid, 1);
         checkOutput({name, ".wb_early"}, wb_valid, 0);
         checkOutput({name, ".addr"}, mem.mem_addr, expAddr);
         checkOutput({name, ".wen"}, mem.mem_wen, w);
         checkOutput({name, ".wstrb"}, mem.mem_wstrb, expStrb);
         checkOutput({name, ".wdata"}, mem.mem_wdata, expWdata);
         for (int i = 0; i < reqStall; i++) begin
            mem.mem_req_ready = 1'b0;
            @(negedge clk);
            cyc++;
            checkOutput({name, ".stall_valid"}, mem.mem_req_valid, 1);
            checkOutput({name, ".stall_addr"}, mem.mem_addr, expAddr);
            checkOutput({name, ".stall_wstrb"}, mem.mem_wstrb, expStrb);
            checkOutput({name, ".stall_wdata"}, mem.mem_wdata, expWdata);
         end
         mem.mem_req_ready = 1'b1;
         @(negedge clk);
         cyc++;
         mem.mem_req_ready = 1'b0;
         checkOutput({name, ".resp_ready"}, mem.mem_resp_ready, 1);
         for (int i = 0; i < respDelay; i++) begin
            mem.mem_resp_valid = 1'b0;
            @(negedge clk);
            cyc++;
         end
         checkOutput({name, ".wb_pre"}, wb_valid, 0);
         mem.mem_resp_valid = 1'b1;
         mem.mem_rdata      = rdata;
         @(negedge clk);
         cyc++;
         mem.mem_resp_valid = 1'b0;
         mem.mem_rdata      = 32'd0;
      end
      checkOutput({name, ".latency"}, cyc, expLat);
      checkOutput({name, ".wb_valid"}, wb_valid, 1);
      checkOutput({name, ".wb_exc"}, wb_exc, expExc);
      checkOutput({name, ".wb_we"}, wb_we, expWe);
      checkOutput({name, ".wb_data"}, wb_data, expData);
      if (!expExc) checkOutput({name, ".wb_rd"}, wb_rd, r);
      @(negedge clk);
      checkOutput({name, ".wb_one"}, wb_valid, 0);
      checkOutput({name, ".idle"}, ex_ready, 1);
   endtask

   initial begin
      int respCycles;
      int n;
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      mem.mem_req_ready  = 1'b0;
      mem.mem_resp_valid = 1'b0;
      mem.mem_rdata      = 32'd0;
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 5'd0);

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst.ex_ready", ex_ready, 1);
      checkOutput("rst.req_valid", mem.mem_req_valid, 0);
      checkOutput("rst.resp_ready", mem.mem_resp_ready, 0);
      checkOutput("rst.addr", mem.mem_addr, 0);
      checkOutput("rst.wb_valid", wb_valid, 0);
      checkOutput("rst.wb_data", wb_data, 0);
      rst = 1'b1;

      // Directed ops: name, addr, wdata, wen, size, unsigned, rd, rdata,
      // reqStall, respDelay, misaligned, mem_addr, wstrb, mem_wdata,
      // wb_data, wb_we, wb_exc, latency.
      runOp("lb_sign", 32'h8000_0003, 32'd0, 1'b0, 2'b00, 1'b0, 5'd5, 32'h80FF_FFFF, 0, 0,
            1'b0, 32'h8000_0000, 4'b0000, 32'd0, 32'hFFFF_FF80, 1'b1, 1'b0, 3);
      runOp("sh_hi", 32'h8000_0002, 32'h0000_ABCD, 1'b1, 2'b01, 1'b0, 5'd3, 32'h1234_5678, 0, 0,
            1'b0, 32'h8000_0000, 4'b1100, 32'hABCD_ABCD, 32'd0, 1'b0, 1'b0, 3);
      runOp("lw_mis", 32'h8000_0001, 32'd0, 1'b0, 2'b10, 1'b0, 5'd6, 32'd0, 0, 0,
            1'b1, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 1);
      runOp("sw_stall", 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0, 5'd0, 32'd0, 3, 0,
            1'b0, 32'h8000_0010, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 6);
      runOp("lbu", 32'h8000_0001, 32'd0, 1'b0, 2'b00, 1'b1, 5'd7, 32'h1234_F6AB, 0, 0,
            1'b0, 32'h8000_0000, 4'b0000, 32'd0, 32'h0000_00F6, 1'b1, 1'b0, 3);
      runOp("lh_sign", 32'h8000_0002, 32'd0, 1'b0, 2'b01, 1'b0, 5'd10, 32'h9ABC_1234, 0, 2,
            1'b0, 32'h8000_0000, 4'b0000, 32'd0, 32'hFFFF_9ABC, 1'b1, 1'b0, 5);
      runOp("lhu", 32'h8000_0000, 32'd0, 1'b0, 2'b01, 1'b1, 5'd11, 32'h9ABC_8001, 0, 0,
            1'b0, 32'h8000_0000, 4'b0000, 32'd0, 32'h0000_8001, 1'b1, 1'b0, 3);
      runOp("lw_rd0", 32'h8000_0004, 32'd0, 1'b0, 2'b10, 1'b1, 5'd0, 32'hCAFE_F00D, 0, 0,
            1'b0, 32'h8000_0004, 4'b0000, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0, 3);
      runOp("sb", 32'h8000_0001, 32'h0000_00A5, 1'b1, 2'b00, 1'b0, 5'd2, 32'd0, 0, 1,
            1'b0, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0, 4);
      runOp("size11", 32'h8000_0008, 32'd0, 1'b0, 2'b11, 1'b0, 5'd9, 32'd0, 0, 0,
            1'b1, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 1);
      runOp("lh_mis", 32'h8000_0003, 32'd0, 1'b0, 2'b01, 1'b0, 5'd9, 32'd0, 0, 0,
            1'b1, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 1);
      runOp("lw_sign", 32'h8000_0008, 32'd0, 1'b0, 2'b10, 1'b0, 5'd12, 32'h8000_0000, 0, 0,
            1'b0, 32'h8000_0008, 4'b0000, 32'd0, 32'h8000_0000, 1'b1, 1'b0, 3);
      runOp("resp_wins", 32'h8000_000C, 32'd0, 1'b0, 2'b10, 1'b0, 5'd1, 32'h1122_3344, 0, 254,
            1'b0, 32'h8000_000C, 4'b0000, 32'd0, 32'h1122_3344, 1'b1, 1'b0, 257);

      // Timeout: no response ever arrives.
      @(negedge clk);
      applyStimulus(1'b1, 32'h8000_0020, 32'd0, 1'b0, 2'b10, 1'b0, 5'd4);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 5'd0);
      checkOutput("to.req_valid", mem.mem_req_valid, 1);
      mem.mem_req_ready = 1'b1;
      @(negedge clk);
      mem.mem_req_ready = 1'b0;
      respCycles = 0;
      n = 0;
      while (wb_valid !== 1'b1 && n < 400) begin
         if (mem.mem_resp_ready) respCycles++;
         @(negedge clk);
         n++;
      end
      checkOutput("to.wb_valid", wb_valid, 1);
      checkOutput("to.resp_cycles", respCycles, 255);
      checkOutput("to.wb_exc", wb_exc, 1);
      checkOutput("to.wb_we", wb_we, 0);
      checkOutput("to.wb_data", wb_data, 0);
      @(negedge clk);
      checkOutput("to.idle", ex_ready, 1);

      // No accept during WB: hold ex_valid through a misaligned completion.
      @(negedge clk);
      applyStimulus(1'b1, 32'h8000_0002, 32'd0, 1'b0, 2'b10, 1'b0, 5'd8);
      @(negedge clk);
      checkOutput("b2b.wb1", wb_valid, 1);
      checkOutput("b2b.not_ready", ex_ready, 0);
      @(negedge clk);
      checkOutput("b2b.gap", wb_valid, 0);
      checkOutput("b2b.ready", ex_ready, 1);
      @(negedge clk);
      checkOutput("b2b.wb2", wb_valid, 1);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 5'd0);
      @(negedge clk);

      // Reset asserted mid-RESP drops the op.
      @(negedge clk);
      applyStimulus(1'b1, 32'h8000_0030, 32'd0, 1'b0, 2'b10, 1'b0, 5'd13);
      @(negedge clk);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 5'd0);
      mem.mem_req_ready = 1'b1;
      @(negedge clk);
      mem.mem_req_ready = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("mid.resp_ready", mem.mem_resp_ready, 1);
      rst = 1'b0;
      #1;
      checkOutput("mid.ex_ready", ex_ready, 1);
      checkOutput("mid.resp_ready0", mem.mem_resp_ready, 0);
      checkOutput("mid.wb_valid", wb_valid, 0);
      @(negedge clk);
      rst = 1'b1;
      mem.mem_resp_valid = 1'b1;
      mem.mem_rdata      = 32'h5555_AAAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("mid.no_wb", wb_valid, 0);
         checkOutput("mid.idle", ex_ready, 1);
         checkOutput("mid.ignore_resp", mem.mem_resp_ready, 0);
      end
      mem.mem_resp_valid = 1'b0;
      mem.mem_rdata      = 32'd0;

      // First op after reset release is accepted immediately.
      runOp("post_rst", 32'h8000_0005, 32'd0, 1'b0, 2'b00, 1'b0, 5'd14, 32'h0000_7F00, 0, 0,
            1'b0, 32'h8000_0004, 4'b0000, 32'd0, 32'h0000_007F, 1'b1, 1'b0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
